// File: rtl/gshare_branch_predictor_if.sv
// Fetch/execute bundle between the pipeline and the gshare branch predictor.
// Latency: none, this is wiring only.
// Backpressure: the pipeline's stall and flush qualifiers travel with the bundle.
interface gshare_branch_predictor_if #(
   parameter int GHR_BITS = 8
);
   // Fetch-stage request and prediction
   logic [31:0]         pc_f_i;
   logic                stall_f_i;
   logic                pred_taken_f_o;
   logic [31:0]         pred_target_f_o;
   logic [GHR_BITS-1:0] ghr_f_o;
   // Execute-stage resolution and redirect
   logic                update_valid_e_i;
   logic                stall_e_i;
   logic                flush_e_i;
   logic [31:0]         pc_e_i;
   logic                taken_e_i;
   logic [31:0]         target_e_i;
   logic                pred_taken_e_i;
   logic [31:0]         pred_target_e_i;
   logic [GHR_BITS-1:0] ghr_e_i;
   logic                mispredict_e_o;

   modport master (
      output pc_f_i, stall_f_i, update_valid_e_i, stall_e_i, flush_e_i, pc_e_i,
             taken_e_i, target_e_i, pred_taken_e_i, pred_target_e_i, ghr_e_i,
      input  pred_taken_f_o, pred_target_f_o, ghr_f_o, mispredict_e_o
   );

   modport slave (
      input  pc_f_i, stall_f_i, update_valid_e_i, stall_e_i, flush_e_i, pc_e_i,
             taken_e_i, target_e_i, pred_taken_e_i, pred_target_e_i, ghr_e_i,
      output pred_taken_f_o, pred_target_f_o, ghr_f_o, mispredict_e_o
   );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal direction predictor with a PC-indexed BTB and speculative history.
// Latency: prediction and mispredict are combinational; training lands at the next edge.
// Backpressure: stall_f holds history; stall_e/flush_e suppress training and redirect.
module gshare_branch_predictor #(
   parameter int IDX_BITS = 8,
   parameter int GHR_BITS = 8,
   parameter int MODE     = 1
) (
   input logic                    clk_i,
   input logic                    reset_n_i,
   gshare_branch_predictor_if.slave bp
);
   localparam int TAG_BITS = 30 - IDX_BITS;
   localparam int ENTRIES  = 1 << IDX_BITS;

   logic [1:0]          ct [ENTRIES];
   logic [ENTRIES-1:0]  btb_valid;
   logic [TAG_BITS-1:0] btb_tag [ENTRIES];
   logic [31:0]         btb_target [ENTRIES];
   logic [GHR_BITS-1:0] ghr;

   logic [IDX_BITS-1:0] ghr_ext, ghr_e_ext;
   logic [IDX_BITS-1:0] fetch_idx, update_idx, fetch_btb_idx, update_btb_idx;
   logic                fetch_hit, fetch_taken, effective;
   logic [GHR_BITS-1:0] ghr_next;
   logic                unused_pc_bits;

   assign unused_pc_bits = ^{bp.pc_f_i[1:0], bp.pc_e_i[1:0]};

   // Index generation: the BTB is always PC-indexed, the counter table folds in history in gshare mode
   always_comb begin
      ghr_ext                     = '0;
      ghr_ext[GHR_BITS-1:0]       = ghr;
      ghr_e_ext                   = '0;
      ghr_e_ext[GHR_BITS-1:0]     = bp.ghr_e_i;
      fetch_btb_idx               = bp.pc_f_i[IDX_BITS+1:2];
      update_btb_idx              = bp.pc_e_i[IDX_BITS+1:2];
      fetch_idx                   = (MODE == 1) ? (fetch_btb_idx ^ ghr_ext) : fetch_btb_idx;
      update_idx                  = (MODE == 1) ? (update_btb_idx ^ ghr_e_ext) : update_btb_idx;
   end

   // Fetch-side prediction; reads only state and F inputs, so updates are seen one edge later
   always_comb begin
      fetch_hit          = btb_valid[fetch_btb_idx] &&
                           (btb_tag[fetch_btb_idx] == bp.pc_f_i[31:IDX_BITS+2]);
      fetch_taken        = fetch_hit && ct[fetch_idx][1];
      bp.pred_taken_f_o  = fetch_taken;
      bp.pred_target_f_o = fetch_taken ? btb_target[fetch_btb_idx] : 32'h0;
      bp.ghr_f_o         = ghr;
   end

   // Resolution: an update only counts when valid, not stalled, not flushed and out of reset
   always_comb begin
      effective         = reset_n_i && bp.update_valid_e_i && !bp.stall_e_i && !bp.flush_e_i;
      bp.mispredict_e_o = effective &&
                          ((bp.taken_e_i != bp.pred_taken_e_i) ||
                           (bp.taken_e_i && (bp.target_e_i != bp.pred_target_e_i)));
   end

   // History next state: recovery from the F snapshot beats the speculative shift
   always_comb begin
      if (bp.mispredict_e_o)
         ghr_next = GHR_BITS'({bp.ghr_e_i, bp.taken_e_i});
      else if (!bp.stall_f_i && fetch_hit)
         ghr_next = GHR_BITS'({ghr, fetch_taken});
      else
         ghr_next = ghr;
   end

   // Saturating 2-bit counters, weakly not-taken after reset
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < ENTRIES; i++) ct[i] <= 2'b01;
      end else if (effective) begin
         if (bp.taken_e_i && ct[update_idx] != 2'b11)
            ct[update_idx] <= ct[update_idx] + 2'd1;
         else if (!bp.taken_e_i && ct[update_idx] != 2'b00)
            ct[update_idx] <= ct[update_idx] - 2'd1;
      end
   end

   // BTB valid bits: only taken resolutions allocate
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         btb_valid <= '0;
      else if (effective && bp.taken_e_i)
         btb_valid[update_btb_idx] <= 1'b1;
   end

   // BTB payload needs no reset since valid gates every use
   always_ff @(posedge clk_i) begin
      if (effective && bp.taken_e_i) begin
         btb_tag[update_btb_idx]    <= bp.pc_e_i[31:IDX_BITS+2];
         btb_target[update_btb_idx] <= bp.target_e_i;
      end
   end

   // Speculative global history register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         ghr <= '0;
      else
         ghr <= ghr_next;
   end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for the predictor: a bimodal and a gshare instance share one stimulus stream.
// Latency: outputs compared against an array model every cycle at the falling edge.
// Backpressure: directed stall/flush vectors exercise the suppression paths.
module tb_gshare_branch_predictor;
   logic clk;
   logic rst_n;

   logic [31:0] pc_f, pc_e, tgt_e, ptgt_e;
   logic        stall_f, uv, stall_e, flush_e, tk, pt_e;
   logic [7:0]  ghr_e;

   int total = 0;
   int bad   = 0;

   gshare_branch_predictor_if #(.GHR_BITS(8)) bi0 ();
   gshare_branch_predictor_if #(.GHR_BITS(8)) bi1 ();

   assign bi0.pc_f_i = pc_f;            assign bi1.pc_f_i = pc_f;
   assign bi0.stall_f_i = stall_f;      assign bi1.stall_f_i = stall_f;
   assign bi0.update_valid_e_i = uv;    assign bi1.update_valid_e_i = uv;
   assign bi0.stall_e_i = stall_e;      assign bi1.stall_e_i = stall_e;
   assign bi0.flush_e_i = flush_e;      assign bi1.flush_e_i = flush_e;
   assign bi0.pc_e_i = pc_e;            assign bi1.pc_e_i = pc_e;
   assign bi0.taken_e_i = tk;           assign bi1.taken_e_i = tk;
   assign bi0.target_e_i = tgt_e;       assign bi1.target_e_i = tgt_e;
   assign bi0.pred_taken_e_i = pt_e;    assign bi1.pred_taken_e_i = pt_e;
   assign bi0.pred_target_e_i = ptgt_e; assign bi1.pred_target_e_i = ptgt_e;
   assign bi0.ghr_e_i = ghr_e;          assign bi1.ghr_e_i = ghr_e;

   gshare_branch_predictor #(.IDX_BITS(8), .GHR_BITS(8), .MODE(0)) dut0 (
      .clk_i(clk), .reset_n_i(rst_n), .bp(bi0.slave));
   gshare_branch_predictor #(.IDX_BITS(8), .GHR_BITS(8), .MODE(1)) dut1 (
      .clk_i(clk), .reset_n_i(rst_n), .bp(bi1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state, index [mode][entry]
   int          m_ct  [2][256];
   bit          m_bv  [2][256];
   logic [21:0] m_tag [2][256];
   logic [31:0] m_tgt [2][256];
   logic [7:0]  m_ghr [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int ct_index(int m, logic [31:0] pc, logic [7:0] h);
      int slot;
      slot = int'(pc[9:2]);
      if (m == 1) slot = slot ^ int'(h);
      return slot;
   endfunction

   function automatic bit m_hit(int m);
      int b;
      b = int'(pc_f[9:2]);
      return m_bv[m][b] && (m_tag[m][b] == pc_f[31:10]);
   endfunction

   function automatic bit m_taken(int m);
      return m_hit(m) && (m_ct[m][ct_index(m, pc_f, m_ghr[m])] >= 2);
   endfunction

   function automatic bit m_mis();
      bit eff;
      eff = rst_n && uv && !stall_e && !flush_e;
      return eff && ((tk != pt_e) || (tk && (tgt_e != ptgt_e)));
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_ghr[m] = 8'h00;
         for (int i = 0; i < 256; i++) begin
            m_ct[m][i] = 1;
            m_bv[m][i] = 1'b0;
         end
      end
   endtask

   task automatic model_update();
      bit mis, hit, pt;
      int u, b;
      if (!rst_n) begin
         model_reset();
         return;
      end
      for (int m = 0; m < 2; m++) begin
         mis = m_mis();
         hit = m_hit(m);
         pt  = m_taken(m);
         if (rst_n && uv && !stall_e && !flush_e) begin
            u = ct_index(m, pc_e, ghr_e);
            if (tk) m_ct[m][u] = (m_ct[m][u] == 3) ? 3 : m_ct[m][u] + 1;
            else    m_ct[m][u] = (m_ct[m][u] == 0) ? 0 : m_ct[m][u] - 1;
            if (tk) begin
               b = int'(pc_e[9:2]);
               m_bv[m][b]  = 1'b1;
               m_tag[m][b] = pc_e[31:10];
               m_tgt[m][b] = tgt_e;
            end
         end
         if (mis)                m_ghr[m] = {ghr_e[6:0], tk};
         else if (!stall_f && hit) m_ghr[m] = {m_ghr[m][6:0], pt};
      end
   endtask

   task automatic compare_all();
      logic [31:0] et;
      et = m_taken(0) ? m_tgt[0][pc_f[9:2]] : 32'h0;
      chk("m0_pred_taken",  {31'h0, bi0.pred_taken_f_o}, {31'h0, m_taken(0)});
      chk("m0_pred_target", bi0.pred_target_f_o, et);
      chk("m0_ghr",         {24'h0, bi0.ghr_f_o}, {24'h0, m_ghr[0]});
      chk("m0_mispredict",  {31'h0, bi0.mispredict_e_o}, {31'h0, m_mis()});
      et = m_taken(1) ? m_tgt[1][pc_f[9:2]] : 32'h0;
      chk("m1_pred_taken",  {31'h0, bi1.pred_taken_f_o}, {31'h0, m_taken(1)});
      chk("m1_pred_target", bi1.pred_target_f_o, et);
      chk("m1_ghr",         {24'h0, bi1.ghr_f_o}, {24'h0, m_ghr[1]});
      chk("m1_mispredict",  {31'h0, bi1.mispredict_e_o}, {31'h0, m_mis()});
   endtask

   // One cycle: compare at the falling edge, advance the model at the rising edge
   task automatic step();
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tg, input logic p, input logic [31:0] ptg,
                          input logic [7:0] g);
      uv = v; pc_e = pc; tk = t; tgt_e = tg; pt_e = p; ptgt_e = ptg; ghr_e = g;
   endtask

   initial begin
      rst_n = 1'b1;
      pc_f = 32'h100; stall_f = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h00);
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      // Reset state at fetch 0x100
      chk("rst_pred_taken", {31'h0, bi0.pred_taken_f_o}, 32'h0);
      chk("rst_target",     bi0.pred_target_f_o, 32'h0);
      chk("rst_ghr",        {24'h0, bi1.ghr_f_o}, 32'h0);
      step(); step();
      rst_n = 1'b1;
      step();

      // Two taken updates to 0x100 with a not-taken prediction
      pc_f = 32'h500;
      set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 8'h00);
      #1 chk("train1_mispredict", {31'h0, bi0.mispredict_e_o}, 32'h1);
      step();
      chk("train2_mispredict", {31'h0, bi0.mispredict_e_o}, 32'h1);
      step();
      uv = 1'b0; pc_f = 32'h100;
      #1;
      chk("trained_taken",  {31'h0, bi0.pred_taken_f_o}, 32'h1);
      chk("trained_target", bi0.pred_target_f_o, 32'h200);
      step();

      // Four not-taken updates saturate at zero; one taken then gives weakly not-taken
      set_upd(1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 8'h00);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("dec_pred_taken", {31'h0, bi0.pred_taken_f_o}, (i == 0) ? 32'h1 : 32'h0);
      end
      set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 8'h00);
      step();
      chk("sat_floor", {31'h0, bi0.pred_taken_f_o}, 32'h0);

      // Recovery: load 0x5A, then recovery from 0x3C beats a fetch-hit shift
      set_upd(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 32'h0, 8'h2D);
      pc_f = 32'h500; stall_f = 1'b1;
      step();
      chk("ghr_5a", {24'h0, bi1.ghr_f_o}, 32'h5A);
      set_upd(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 32'h0, 8'h3C);
      pc_f = 32'h100; stall_f = 1'b0;
      #1 chk("recover_mispredict", {31'h0, bi1.mispredict_e_o}, 32'h1);
      step();
      chk("ghr_78", {24'h0, bi1.ghr_f_o}, 32'h78);
      // Speculative shift of a not-taken hit, then hold under fetch stall
      uv = 1'b0;
      step();
      chk("ghr_shift", {24'h0, bi0.ghr_f_o}, 32'hF0);
      stall_f = 1'b1;
      step();
      chk("ghr_hold", {24'h0, bi1.ghr_f_o}, 32'hF0);

      // Flushed then stalled taken update at 0x300 has no effect
      pc_f = 32'h300;
      set_upd(1'b1, 32'h300, 1'b1, 32'h400, 1'b0, 32'h0, 8'h00);
      flush_e = 1'b1;
      #1 chk("flush_mispredict", {31'h0, bi0.mispredict_e_o}, 32'h0);
      step();
      flush_e = 1'b0; stall_e = 1'b1;
      #1 chk("stall_mispredict", {31'h0, bi1.mispredict_e_o}, 32'h0);
      step();
      stall_e = 1'b0; uv = 1'b0;
      #1;
      chk("flush_no_alloc", {31'h0, bi1.pred_taken_f_o}, 32'h0);
      chk("flush_ghr",      {24'h0, bi0.ghr_f_o}, 32'hF0);
      step();

      // Correct prediction, then a target mismatch
      pc_f = 32'h100;
      set_upd(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 8'h00);
      #1 chk("match_no_mispredict", {31'h0, bi0.mispredict_e_o}, 32'h0);
      step();
      ptgt_e = 32'h204;
      #1 chk("target_mispredict", {31'h0, bi1.mispredict_e_o}, 32'h1);
      step();
      uv = 1'b0;
      #1 chk("retrained_taken", {31'h0, bi0.pred_taken_f_o}, 32'h1);
      step();

      // Mid-cycle reset with an update still asserted
      uv = 1'b1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_taken",  {31'h0, bi0.pred_taken_f_o}, 32'h0);
      chk("mid_rst_target", bi0.pred_target_f_o, 32'h0);
      chk("mid_rst_ghr",    {24'h0, bi1.ghr_f_o}, 32'h0);
      chk("mid_rst_mis",    {31'h0, bi1.mispredict_e_o}, 32'h0);
      model_reset();
      step();
      rst_n = 1'b1; uv = 1'b0;
      #1 chk("post_rst_taken", {31'h0, bi0.pred_taken_f_o}, 32'h0);
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
